apb5_regfile_completer: RTL and testbench
=========================================

# apb5_regfile_completer

APB5 completer: a parameterised register file that answers APB5 requester transfers with programmable wait states and PSLVERR checks. It drives the completer-sourced signals PREADY, PRDATA, PSLVERR, PRUSER and PBUSER. It stands in as the DUT-side target for the APB5 VIP and as a reusable peripheral CSR block.

## Interface
Parameters:
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width (8, 16 or 32)
- USER_REQ_WIDTH, 128, PAUSER width
- USER_DATA_WIDTH, DATA_WIDTH/2, PWUSER/PRUSER/PBUSER width (≥3)
- NUM_REGS, 16, register count (power of 2, ≥2)
- WAIT_STATES, 0, PREADY-low cycles in access phase (0..15)
- ID_VALUE, 32'hA5B5_0001, read-only contents of reg 0

Ports:
- pclk  in  1  clock
- presetn  in  1  reset, **asynchronous, active-low**
- paddr  in  ADDR_WIDTH  address
- pprot  in  3  protection; bit1 = 1 means non-secure
- pselx  in  1  select
- penable  in  1  access phase
- pwrite  in  1  1 = write
- pwdata  in  DATA_WIDTH  write data
- pstrb  in  DATA_WIDTH/8  write byte strobes
- pwakeup  in  1  ignored
- pauser  in  USER_REQ_WIDTH  request user bits
- pwuser  in  USER_DATA_WIDTH  ignored
- pready  out  1  transfer complete
- prdata  out  DATA_WIDTH  read data
- pslverr  out  1  error response
- pruser  out  USER_DATA_WIDTH  read user bits
- pbuser  out  USER_DATA_WIDTH  response code
- regs_o  out  NUM_REGS*DATA_WIDTH  flat register contents, reg 0 at LSBs

## Operation
- FSM states IDLE, WAIT and RESP. It resets to IDLE.
- IDLE: when pselx=1 and penable=0 (setup), latch the decode results and the pauser LSBs, then load the counter with WAIT_STATES.
  - Go to RESP if WAIT_STATES=0, otherwise go to WAIT.
- WAIT: decrement the counter on each cycle where pselx=1 and penable=1. Go to RESP when the counter reaches 1. If pselx=0, abort to IDLE with no write.
- RESP: pready=1 for exactly one cycle. The transfer completes at that edge, and the FSM returns to IDLE.
  - Back-to-back transfers: the next setup cycle is the cycle after RESP.
- Decode uses byte address A and W = DATA_WIDTH/8. Checks are prioritised; the first failing check sets the code:
  - 1: A ≥ NUM_REGS*W (decode error)
  - 2: A mod W ≠ 0 (misaligned)
  - 3: index 1 accessed with pprot[1]=1 (secure-only)
  - 4: write to index 0 (read-only)
  - 5: read with pstrb ≠ 0
  - 0: OK
- Error (code ≠ 0): pslverr=1 with pready, prdata=0, and no register changes.
- OK write: at the RESP edge, each register byte with pstrb[i]=1 takes pwdata byte i. Other bytes are unchanged.
- OK read: prdata = register value.
- pruser = pauser[USER_DATA_WIDTH-1:0] on reads and 0 on writes. pbuser = code, zero-extended. Both are valid only while pready=1 and are 0 otherwise.

## Timing
- Reset values: pready=0, prdata=0, pslverr=0, pruser=0, pbuser=0, all registers 0 except reg 0 = ID_VALUE, FSM in IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Transfer length is 2+WAIT_STATES cycles: setup, then WAIT_STATES cycles with pready=0, then one access cycle with pready=1.
- prdata, pslverr, pruser and pbuser change only on the edge that raises pready. They return to 0 on the following edge.
- Write data and strobes are sampled on the RESP edge; the write takes effect in the next cycle.
- Reset mid-transfer: outputs return to reset values immediately (asynchronous). Any pending write is lost.
- penable=1 seen in IDLE (protocol violation): ignored, stay in IDLE.

## Structure
- Package apb5_pkg holds:
  - enum state_e {IDLE, WAIT, RESP}
  - enum err_code_e {ERR_OK=0, ERR_DECODE=1, ERR_ALIGN=2, ERR_PROT=3, ERR_RO=4, ERR_RDSTRB=5}
  - constant PPROT_NONSEC_BIT=1
- Sub-module apb5_regfile_decode: combinational address, protection and strobe checks that output index and err_code_e. The top level holds the FSM, wait counter and register array.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF with strobe 0xF to 0x8, then read 0x8 → pready in the 2nd cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
- WAIT_STATES=3: read 0x0 → pready low for 3 access cycles, then high for 1 cycle, prdata=0xA5B50001, and the transfer spans 5 cycles.
- Partial write: reg 2=0x11223344, then write 0xAABBCCDD with strobe 0x5 → reads back 0x11BB33DD.
- Errors, each returning pslverr=1 with no register change:
  - read 0x40 → pbuser=1
  - read 0x6 → pbuser=2
  - write 0x4 with pprot=3'b010 → pbuser=3, reg 1 unchanged
  - write 0x0 → pbuser=4
  - read 0x8 with pstrb=0x1 → pbuser=5
- Read with pauser=0x…1234 (DATA_WIDTH=32) → pruser=0x1234; a write transfer returns pruser=0.
- Assert presetn in the 2nd wait cycle of a write to reg 3 → all outputs 0 immediately, reg 3 remains 0, and the next transfer after release completes normally.

Source files
------------

// File: rtl/apb5_pkg.sv
// rtl/apb5_pkg.sv - shared types and constants for the APB5 register file completer
package apb5_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [2:0] {
    ERR_OK     = 3'd0,
    ERR_DECODE = 3'd1,
    ERR_ALIGN  = 3'd2,
    ERR_PROT   = 3'd3,
    ERR_RO     = 3'd4,
    ERR_RDSTRB = 3'd5
  } err_code_e;

  localparam int PPROT_NONSEC_BIT = 1;

endpackage

// File: rtl/apb5_regfile_decode.sv
// rtl/apb5_regfile_decode.sv - address, protection and strobe checks for one APB transfer
module apb5_regfile_decode
  import apb5_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic [ADDR_WIDTH-1:0]       paddr_i,
  input  logic [2:0]                  pprot_i,
  input  logic                        pwrite_i,
  input  logic [DATA_WIDTH/8-1:0]     pstrb_i,
  output logic [$clog2(NUM_REGS)-1:0] idx_o,
  output err_code_e                   err_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_REGS);
  localparam int OB = $clog2(SW);

  // Only the non-secure bit of pprot matters to this block.
  logic unused_prot;
  assign unused_prot = pprot_i[0] ^ pprot_i[2];

  assign idx_o = IW'(paddr_i >> OB);

  // Prioritised checks: the first rule that fails picks the response code.
  always_comb begin
    err_o = ERR_OK;
    if (paddr_i >= ADDR_WIDTH'(NUM_REGS * SW)) begin
      err_o = ERR_DECODE;
    end else if ((paddr_i & ADDR_WIDTH'(SW - 1)) != '0) begin
      err_o = ERR_ALIGN;
    end else if (idx_o == IW'(1) && pprot_i[PPROT_NONSEC_BIT]) begin
      err_o = ERR_PROT;
    end else if (pwrite_i && idx_o == '0) begin
      err_o = ERR_RO;
    end else if (!pwrite_i && pstrb_i != '0) begin
      err_o = ERR_RDSTRB;
    end
  end

endmodule

// File: rtl/apb5_regfile_completer.sv
// rtl/apb5_regfile_completer.sv - APB5 completer with register array, wait states and error codes
module apb5_regfile_completer
  import apb5_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 32,
  parameter int          USER_REQ_WIDTH  = 128,
  parameter int          USER_DATA_WIDTH = DATA_WIDTH / 2,
  parameter int          NUM_REGS        = 16,
  parameter int          WAIT_STATES     = 0,
  parameter logic [31:0] ID_VALUE        = 32'hA5B5_0001
) (
  input  logic                           pclk,
  input  logic                           presetn,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [2:0]                     pprot,
  input  logic                           pselx,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  input  logic                           pwakeup,
  input  logic [USER_REQ_WIDTH-1:0]      pauser,
  input  logic [USER_DATA_WIDTH-1:0]     pwuser,
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  output logic [USER_DATA_WIDTH-1:0]     pruser,
  output logic [USER_DATA_WIDTH-1:0]     pbuser,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int IW  = $clog2(NUM_REGS);
  localparam int UDW = USER_DATA_WIDTH;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d, dec_idx;
  err_code_e             code_q, code_d, dec_code;
  logic                  write_q, write_d;
  logic [UDW-1:0]        user_q, user_d;
  logic                  resp_go;
  logic                  pready_q, pready_d, pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [UDW-1:0]        pruser_q, pruser_d, pbuser_q, pbuser_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // pwakeup and pwuser carry no meaning here; pauser contributes only its low bits.
  logic unused_inputs;
  assign unused_inputs = pwakeup ^ (^pwuser) ^ (^pauser);

  apb5_regfile_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_decode (
    .paddr_i (paddr),
    .pprot_i (pprot),
    .pwrite_i(pwrite),
    .pstrb_i (pstrb),
    .idx_o   (dec_idx),
    .err_o   (dec_code)
  );

  // Next state: capture the transfer in setup, count wait states, then one response cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    code_d  = code_q;
    write_d = write_q;
    user_d  = user_q;
    case (state_q)
      IDLE: begin
        if (pselx && !penable) begin
          idx_d   = dec_idx;
          code_d  = dec_code;
          write_d = pwrite;
          user_d  = pauser[UDW-1:0];
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!pselx) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q <= 4'd1) state_d = RESP;
          else cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response outputs are loaded on the edge entering RESP and cleared on every other edge.
  always_comb begin
    resp_go   = (state_d == RESP);
    pready_d  = resp_go;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    pruser_d  = '0;
    pbuser_d  = '0;
    if (resp_go) begin
      pslverr_d = (code_d != ERR_OK);
      pbuser_d  = UDW'(code_d);
      if (!write_d) begin
        pruser_d = user_d;
        if (code_d == ERR_OK) prdata_d = regs_q[idx_d];
      end
    end
  end

  // FSM state and the per-transfer latched decode.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      code_q  <= ERR_OK;
      write_q <= 1'b0;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      write_q <= write_d;
      user_q  <= user_d;
    end
  end

  // Registered completer outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      pruser_q  <= '0;
      pbuser_q  <= '0;
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      pruser_q  <= pruser_d;
      pbuser_q  <= pbuser_d;
    end
  end

  // Register array: strobed byte writes commit on the edge that ends an error-free RESP.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= (r == 0) ? DATA_WIDTH'(ID_VALUE) : '0;
      end
    end else if (state_q == RESP && write_q && code_q == ERR_OK) begin
      for (int b = 0; b < SW; b++) begin
        if (pstrb[b]) regs_q[idx_q][8*b +: 8] <= pwdata[8*b +: 8];
      end
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;
  assign pruser  = pruser_q;
  assign pbuser  = pbuser_q;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
    assign regs_o[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
  end

endmodule

// File: tb/tb_apb5_regfile_completer.sv
// tb/tb_apb5_regfile_completer.sv - directed bench for two completers (0 and 3 wait states)
module tb_apb5_regfile_completer;

  logic         clk = 1'b0;
  logic         presetn;
  logic [31:0]  paddr;
  logic [2:0]   pprot;
  logic [1:0]   psel;
  logic         penable, pwrite, pwakeup;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [127:0] pauser;
  logic [15:0]  pwuser;

  logic [1:0]   pready_w, pslverr_w;
  logic [31:0]  prdata_w [2];
  logic [15:0]  pruser_w [2];
  logic [15:0]  pbuser_w [2];
  logic [511:0] regs_w [2];

  int cyc = 0;
  int npass = 0;
  int ntot = 0;
  bit chk_en = 1'b0;

  logic [31:0] mdl [2][16];
  int          exp_cyc [2];
  logic [31:0] exp_rd [2];
  logic        exp_err [2];
  logic [15:0] exp_ru [2];
  logic [15:0] exp_bu [2];

  logic [31:0] r_rd;
  logic        r_err;
  logic [15:0] r_ru, r_bu;
  int          r_lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  apb5_regfile_completer #(.WAIT_STATES(0)) dut0 (
    .pclk(clk), .presetn(presetn), .paddr(paddr), .pprot(pprot), .pselx(psel[0]),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pwakeup(pwakeup),
    .pauser(pauser), .pwuser(pwuser), .pready(pready_w[0]), .prdata(prdata_w[0]),
    .pslverr(pslverr_w[0]), .pruser(pruser_w[0]), .pbuser(pbuser_w[0]), .regs_o(regs_w[0])
  );

  apb5_regfile_completer #(.WAIT_STATES(3)) dut3 (
    .pclk(clk), .presetn(presetn), .paddr(paddr), .pprot(pprot), .pselx(psel[1]),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pwakeup(pwakeup),
    .pauser(pauser), .pwuser(pwuser), .pready(pready_w[1]), .prdata(prdata_w[1]),
    .pslverr(pslverr_w[1]), .pruser(pruser_w[1]), .pbuser(pbuser_w[1]), .regs_o(regs_w[1])
  );

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int mcode(input bit wr, input logic [31:0] a, input logic [3:0] st,
                               input logic [2:0] pr);
    int unsigned ua;
    ua = a;
    if (ua >= 16 * 4) return 1;
    if (ua % 4 != 0) return 2;
    if (ua / 4 == 1 && pr[1]) return 3;
    if (wr && ua / 4 == 0) return 4;
    if (!wr && st != 0) return 5;
    return 0;
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      exp_cyc[d] = -1;
      for (int r = 0; r < 16; r++) mdl[d][r] = (r == 0) ? 32'hA5B5_0001 : 32'h0;
    end
  endtask

  // Every cycle: outputs are zero except in the single predicted response cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        bit hit;
        logic [511:0] flat;
        hit = (cyc == exp_cyc[d]);
        for (int r = 0; r < 16; r++) flat[32*r +: 32] = mdl[d][r];
        chk($sformatf("dut%0d pready", d), pready_w[d], hit);
        chk($sformatf("dut%0d prdata", d), prdata_w[d], hit ? exp_rd[d] : 32'h0);
        chk($sformatf("dut%0d pslverr", d), pslverr_w[d], hit ? exp_err[d] : 1'b0);
        chk($sformatf("dut%0d pruser", d), pruser_w[d], hit ? exp_ru[d] : 16'h0);
        chk($sformatf("dut%0d pbuser", d), pbuser_w[d], hit ? exp_bu[d] : 16'h0);
        chk($sformatf("dut%0d regs", d), regs_w[d], flat);
      end
    end
  end

  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input logic [127:0] us);
    int code;
    int idx;
    code = mcode(wr, a, st, pr);
    idx = int'(a[5:2]);
    exp_cyc[d] = cyc + 1 + ((d == 1) ? 3 : 0);
    exp_err[d] = (code != 0);
    exp_bu[d]  = 16'(code);
    exp_ru[d]  = wr ? 16'h0 : us[15:0];
    exp_rd[d]  = (!wr && code == 0) ? mdl[d][idx] : 32'h0;
    paddr = a; pwrite = wr; pwdata = wd; pstrb = st; pprot = pr; pauser = us;
    psel = 2'b00; psel[d] = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    r_lat = 2;
    @(negedge clk);
    while (!pready_w[d] && r_lat < 20) begin
      @(posedge clk); @(negedge clk);
      r_lat++;
    end
    chk($sformatf("dut%0d transfer length @%h", d, a), r_lat, (d == 1) ? 5 : 2);
    r_rd = prdata_w[d]; r_err = pslverr_w[d]; r_ru = pruser_w[d]; r_bu = pbuser_w[d];
    @(posedge clk);
    if (wr && code == 0)
      for (int b = 0; b < 4; b++) if (st[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
    #1 psel = 2'b00; penable = 1'b0;
  endtask

  initial begin
    presetn = 1'b0; psel = 2'b00; penable = 1'b0; pwrite = 1'b0; paddr = '0; pprot = '0;
    pwdata = '0; pstrb = '0; pwakeup = 1'b0; pauser = '0; pwuser = 16'hFFFF;
    reset_model();
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #1;
    chk("reset id reg", regs_w[0][31:0], 32'hA5B5_0001);
    chk("reset pready", pready_w, 2'b00);
    presetn = 1'b1;

    xfer(0, 1, 32'h8, 32'hDEAD_BEEF, 4'hF, 3'b000, '0);
    chk("wr8 pslverr", r_err, 1'b0);
    xfer(0, 0, 32'h8, 32'h0, 4'h0, 3'b000, '0);
    chk("rd8 prdata", r_rd, 32'hDEAD_BEEF);
    chk("rd8 pslverr", r_err, 1'b0);

    xfer(1, 0, 32'h0, 32'h0, 4'h0, 3'b000, '0);
    chk("ws3 id read", r_rd, 32'hA5B5_0001);

    xfer(0, 1, 32'h8, 32'h1122_3344, 4'hF, 3'b000, '0);
    xfer(0, 1, 32'h8, 32'hAABB_CCDD, 4'h5, 3'b000, '0);
    xfer(0, 0, 32'h8, 32'h0, 4'h0, 3'b000, '0);
    chk("partial write", r_rd, 32'h11BB_33DD);

    xfer(0, 0, 32'h40, 32'h0, 4'h0, 3'b000, '0);
    chk("decode err", {r_err, r_bu, r_rd}, {1'b1, 16'd1, 32'h0});
    xfer(0, 0, 32'h6, 32'h0, 4'h0, 3'b000, '0);
    chk("align err", {r_err, r_bu, r_rd}, {1'b1, 16'd2, 32'h0});
    xfer(0, 1, 32'h4, 32'h55AA_55AA, 4'hF, 3'b000, '0);
    xfer(0, 1, 32'h4, 32'h1234_5678, 4'hF, 3'b010, '0);
    chk("prot err", {r_err, r_bu}, {1'b1, 16'd3});
    xfer(0, 0, 32'h4, 32'h0, 4'h0, 3'b000, '0);
    chk("reg1 unchanged", r_rd, 32'h55AA_55AA);
    xfer(0, 1, 32'h0, 32'hFFFF_FFFF, 4'hF, 3'b000, '0);
    chk("ro err", {r_err, r_bu}, {1'b1, 16'd4});
    xfer(0, 0, 32'h8, 32'h0, 4'h1, 3'b000, '0);
    chk("rdstrb err", {r_err, r_bu, r_rd}, {1'b1, 16'd5, 32'h0});
    xfer(1, 0, 32'h40, 32'h0, 4'h0, 3'b000, '0);
    chk("ws3 decode err", {r_err, r_bu}, {1'b1, 16'd1});

    xfer(0, 0, 32'h8, 32'h0, 4'h0, 3'b000, 128'hCAFE_0000_0000_0000_0000_0000_0000_1234);
    chk("read pruser", r_ru, 16'h1234);
    xfer(0, 1, 32'hC, 32'h0000_0077, 4'h1, 3'b000, 128'hCAFE_0000_0000_0000_0000_0000_0000_1234);
    chk("write pruser", r_ru, 16'h0);

    // penable without a setup phase must not start a transfer.
    psel = 2'b01; penable = 1'b1;
    repeat (2) @(posedge clk);
    #1 psel = 2'b00; penable = 1'b0;
    @(posedge clk); #1;

    // Dropping pselx during wait states abandons the write.
    paddr = 32'h14; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; pprot = '0;
    psel = 2'b10; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 2'b00; penable = 1'b0;
    repeat (2) @(posedge clk); #1;
    xfer(1, 0, 32'h14, 32'h0, 4'h0, 3'b000, '0);
    chk("aborted write", r_rd, 32'h0);

    // Reset arrives in the second wait cycle of a write to reg 3.
    paddr = 32'hC; pwrite = 1'b1; pwdata = 32'h0BAD_F00D; pstrb = 4'hF; pprot = '0;
    psel = 2'b10; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #3;
    presetn = 1'b0;
    reset_model();
    #1;
    chk("async rst outputs", {pready_w[1], pslverr_w[1], prdata_w[1], pruser_w[1], pbuser_w[1]}, '0);
    chk("async rst reg3", regs_w[1][127:96], 32'h0);
    chk("async rst dut0 reg2", regs_w[0][95:64], 32'h0);
    psel = 2'b00; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1 presetn = 1'b1;
    xfer(1, 0, 32'hC, 32'h0, 4'h0, 3'b000, '0);
    chk("post reset read", {r_err, r_rd}, {1'b0, 32'h0});
    xfer(0, 0, 32'h0, 32'h0, 4'h0, 3'b000, '0);
    chk("post reset id", r_rd, 32'hA5B5_0001);

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
